// File: rtl/md_unit_ctrl_pkg.sv
// Shared encodings and defaults for the multiply/divide unit controller.
// MD_DIV_EN selects whether div/divu count as multi-cycle operations.
package md_unit_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int DEFAULT_MULT_CYCLES = 5;
  localparam int DEFAULT_DIV_CYCLES  = 10;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops that occupy the unit for a counted number of cycles.
  function automatic logic is_long_op(input logic [2:0] op);
`ifdef MD_DIV_EN
    return (op == MD_MULT) || (op == MD_MULTU) || is_div_op(op);
`else
    return (op == MD_MULT) || (op == MD_MULTU);
`endif
  endfunction

endpackage

// File: rtl/md_unit_ctrl_div.sv
// Combinational 32-bit signed/unsigned divider used by md_unit_ctrl.
// Only present when MD_DIV_EN is defined.
`ifdef MD_DIV_EN
module md_div_core (
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        is_signed_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        div_by_zero_o
);

  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, safe_b, uq, ur;

  assign neg_a  = is_signed_i & dividend_i[31];
  assign neg_b  = is_signed_i & divisor_i[31];
  assign mag_a  = neg_a ? (32'd0 - dividend_i) : dividend_i;
  assign mag_b  = neg_b ? (32'd0 - divisor_i)  : divisor_i;

  // Zero divisor is reported separately; substitute 1 to keep the divider defined.
  assign div_by_zero_o = (divisor_i == 32'd0);
  assign safe_b        = div_by_zero_o ? 32'd1 : mag_b;

  assign uq = mag_a / safe_b;
  assign ur = mag_a % safe_b;

  // Quotient truncates toward zero; remainder follows the dividend's sign.
  assign quotient_o  = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
  assign remainder_o = neg_a ? (32'd0 - ur) : ur;

endmodule
`endif

// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide unit controller: fixed-latency mult (and div with
// MD_DIV_EN defined), mthi/mtlo writes, and stall request to the hazard unit.
module md_unit_ctrl
  import md_unit_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [2:0]        op_q, op_d;
  logic [31:0]       a_q, a_d, b_q, b_d;

  logic [63:0]       a_ext, b_ext, prod;
  logic [31:0]       res_hi, res_lo;
  logic              res_wr;

  // Sign- or zero-extend to 64 bits so one multiplier serves mult and multu.
  assign a_ext = (op_q == MD_MULT) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign b_ext = (op_q == MD_MULT) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = a_ext * b_ext;

`ifdef MD_DIV_EN
  logic [31:0] quo, rem;
  logic        div_zero;

  md_div_core u_div (
    .dividend_i    (a_q),
    .divisor_i     (b_q),
    .is_signed_i   (op_q == MD_DIV),
    .quotient_o    (quo),
    .remainder_o   (rem),
    .div_by_zero_o (div_zero)
  );

  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    res_wr = 1'b1;
    if (is_div_op(op_q)) begin
      res_hi = rem;
      res_lo = quo;
      res_wr = !div_zero;
    end
  end
`else
  assign res_hi = prod[63:32];
  assign res_lo = prod[31:0];
  assign res_wr = 1'b1;
`endif

  always_comb begin
    // NOTE: every _d gets a default first so no path through this block can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;

    if (state_q == ST_IDLE) begin
      if (start) begin
        if (is_long_op(md_op)) begin
          op_d    = md_op;
          a_d     = rs_val;
          b_d     = rt_val;
          cnt_d   = is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = ST_BUSY;
          busy_d  = 1'b1;
        end else if (md_op == MD_MTHI) begin
          hi_d = rs_val;
        end else if (md_op == MD_MTLO) begin
          lo_d = rs_val;
        end
      end
    end else begin
      // New starts are deliberately not looked at while busy.
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (res_wr) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall_md = md_use_D & (busy_q | (start & is_long_op(md_op)));

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl against an arithmetic HI/LO model.
// Division expectations follow MD_DIV_EN the same way the design does.
module tb_md_unit_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_use_D;
  logic        busy, stall_md, done;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  md_unit_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: latency and resulting HI/LO for one instruction, from plain arithmetic.
  task automatic model_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int n, output logic [31:0] nh, output logic [31:0] nl);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, up;
    logic [63:0]     p;
    n  = 0;
    nh = hi_m;
    nl = lo_m;
    case (op)
      3'b000: begin
        sa = longint'(int'(rs));
        sb = longint'(int'(rt));
        p  = 64'(sa * sb);
        nh = p[63:32];
        nl = p[31:0];
        n  = MULT_N;
      end
      3'b001: begin
        ua = longint'(rs);
        ub = longint'(rt);
        up = ua * ub;
        p  = 64'(up);
        nh = p[63:32];
        nl = p[31:0];
        n  = MULT_N;
      end
`ifdef MD_DIV_EN
      3'b010, 3'b011: begin
        n = DIV_N;
        if (rt != 32'd0) begin
          if (op == 3'b010) begin
            sa = longint'(int'(rs));
            sb = longint'(int'(rt));
          end else begin
            sa = longint'({32'd0, rs});
            sb = longint'({32'd0, rt});
          end
          q  = sa / sb;
          r  = sa % sb;
          p  = 64'(q);
          nl = p[31:0];
          p  = 64'(r);
          nh = p[31:0];
        end
      end
`endif
      3'b100: nh = rs;
      3'b101: nl = rs;
      default: ;
    endcase
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input bit use_d, input bit poke);
    int          n;
    logic [31:0] nh, nl;
    bit          start_now, busy_e, done_e, stall_e;
    logic [66:0] act_v, exp_v;
    model_op(op, rs, rt, n, nh, nl);

    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = rs; rt_val = rt; md_use_D = use_d;
    #1;
    n_checks++;
    if (stall_md !== (use_d & (n > 0)))
      $display("FAIL %s issue_stall: got %b expected %b", name, stall_md, use_d & (n > 0));
    else n_pass++;

    for (int i = 0; i < n + 3; i++) begin
      @(negedge clk);
      start_now = poke && (i == 1) && (n >= 3);
      start  = start_now;
      md_op  = 3'b001;
      rs_val = $urandom;
      rt_val = $urandom;
      #1;
      busy_e  = (i < n);
      done_e  = (n > 0) && (i == n);
      stall_e = use_d & (busy_e | start_now);
      exp_v = {busy_e, done_e, stall_e, (i >= n) ? nh : hi_m, (i >= n) ? nl : lo_m};
      act_v = {busy, done, stall_md, hi, lo};
      n_checks++;
      if (act_v !== exp_v)
        $display("FAIL %s cyc%0d: got busy=%b done=%b stall=%b hi=%h lo=%h expected busy=%b done=%b stall=%b hi=%h lo=%h",
                 name, i, act_v[66], act_v[65], act_v[64], act_v[63:32], act_v[31:0],
                 exp_v[66], exp_v[65], exp_v[64], exp_v[63:32], exp_v[31:0]);
      else n_pass++;
    end
    start = 1'b0;
    hi_m  = nh;
    lo_m  = nl;
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    n_checks++;
    if ({hi, lo} !== {eh, el})
      $display("FAIL %s: got hi=%h lo=%h expected hi=%h lo=%h", name, hi, lo, eh, el);
    else n_pass++;
  endtask

  task automatic test_reset();
    start = 0; md_op = 0; rs_val = 0; rt_val = 0; md_use_D = 1; reset = 1;
    #2 reset = 0;
    #1;
    n_checks++;
    if ({busy, done, stall_md, hi, lo} !== 67'd0)
      $display("FAIL reset_async: got busy=%b done=%b stall=%b hi=%h lo=%h expected all zero",
               busy, done, stall_md, hi, lo);
    else n_pass++;
    @(posedge clk); #2;
    n_checks++;
    if ({busy, done, hi, lo} !== 66'd0)
      $display("FAIL reset_held: got busy=%b done=%b hi=%h lo=%h expected all zero", busy, done, hi, lo);
    else n_pass++;
    reset = 1;
  endtask

  task automatic test_mult();
    run_op("mult_neg1x2", 3'b000, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b0);
    check_hilo("mult_const", 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu_max_x2", 3'b001, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    check_hilo("multu_const", 32'h00000001, 32'hFFFFFFFE);
  endtask

  task automatic test_mthi_mtlo();
    run_op("mtlo", 3'b101, 32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0);
    check_hilo("mtlo_const", 32'h00000001, 32'h12345678);
    run_op("mthi", 3'b100, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0);
    check_hilo("mthi_const", 32'hCAFEF00D, 32'h12345678);
  endtask

  task automatic test_div();
`ifdef MD_DIV_EN
    run_op("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    check_hilo("div_const", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_by_zero", 3'b010, 32'd77, 32'd0, 1'b1, 1'b0);
    check_hilo("div0_unchanged", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_overflow", 3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check_hilo("div_ovf_const", 32'h00000000, 32'h80000000);
    run_op("divu", 3'b011, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    check_hilo("divu_const", 32'h00000001, 32'h7FFFFFFC);
`else
    run_op("div_disabled", 3'b010, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    check_hilo("div_dis_unchanged", 32'hCAFEF00D, 32'h12345678);
    run_op("divu_disabled", 3'b011, 32'd100, 32'd7, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_stall_and_ignore();
    run_op("mult_poke", 3'b000, 32'h00001234, 32'hFFFF0000, 1'b1, 1'b1);
    run_op("multu_poke", 3'b001, 32'h89ABCDEF, 32'h76543210, 1'b1, 1'b1);
    run_op("undef_110", 3'b110, 32'h11111111, 32'h22222222, 1'b1, 1'b0);
    run_op("undef_111", 3'b111, 32'h33333333, 32'h44444444, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    run_op("pre_mthi", 3'b100, 32'hAAAA5555, 32'h0, 1'b0, 1'b0);
    run_op("pre_mtlo", 3'b101, 32'h5555AAAA, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1; md_op = 3'b000; rs_val = 32'd3; rt_val = 32'd4; md_use_D = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 0;
    #1;
    n_checks++;
    if ({busy, done, stall_md, hi, lo} !== 67'd0)
      $display("FAIL reset_mid_op: got busy=%b done=%b stall=%b hi=%h lo=%h expected all zero",
               busy, done, stall_md, hi, lo);
    else n_pass++;
    @(posedge clk);
    @(posedge clk); #2 reset = 1;
    hi_m = '0;
    lo_m = '0;
    for (int i = 0; i < MULT_N + 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({busy, done, hi, lo} !== 66'd0)
        $display("FAIL after_reset cyc%0d: got busy=%b done=%b hi=%h lo=%h expected all zero",
                 i, busy, done, hi, lo);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int k = 0; k < 24; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'd0;
      if ($urandom_range(0, 7) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      run_op($sformatf("rand%0d_op%0d", k, op), op, a, b, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1; start = 0; md_op = 0; rs_val = 0; rt_val = 0; md_use_D = 0;
    test_reset();
    test_mult();
    test_mthi_mtlo();
    test_div();
    test_stall_and_ignore();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/md_unit_ctrl.md
MD_UNIT_CTRL -- requirements
Module: md_unit_ctrl

Interface
REQ-001 Parameter: MULT_CYCLES, 5, busy cycles for mult/multu (SHALL be >=1).
REQ-002 Parameter: DIV_CYCLES, 10, busy cycles for div/divu (SHALL be >=1).
REQ-003 Port: clk  in  1  single clock, rising-edge.
REQ-004 Port: reset  in  1  asynchronous, active-low reset.
REQ-005 Port: start  in  1  E-stage MD instruction valid this cycle.
REQ-006 Port: md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others ignored.
REQ-007 Port: rs_val  in  32  forwarded rs operand.
REQ-008 Port: rt_val  in  32  forwarded rt operand.
REQ-009 Port: md_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 Port: busy  out  1  operation in progress.
REQ-011 Port: stall_md  out  1  stall request to hazard unit.
REQ-012 Port: hi  out  32  HI register.
REQ-013 Port: lo  out  32  LO register.
REQ-014 Port: done  out  1  one-cycle pulse after HI/LO update by mult/div.

Function
REQ-015 Two states SHALL exist: IDLE, BUSY; a down-counter SHALL track remaining cycles.
REQ-016 IDLE, start with mult/multu/div/divu at edge k: operands and op latched, counter loaded with N (MULT_CYCLES or DIV_CYCLES), state->BUSY; busy=1 cycles k+1..k+N.
REQ-017 Counter SHALL decrement each BUSY cycle; on edge with counter==1: HI/LO written, state->IDLE, busy falls, done=1 the following cycle only.
REQ-018 mult: {hi,lo}=signed rs*rt, 64 bits; multu: unsigned product.
REQ-019 div: lo=signed quotient truncated toward zero, hi=remainder with sign of dividend; divu: unsigned.
REQ-020 0x80000000 div 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-021 Divide by zero: full DIV_CYCLES busy, hi/lo unchanged, done still pulses.
REQ-022 mthi/mtlo in IDLE: hi (resp. lo)=rs_val at that edge, no busy, no done.
REQ-023 start while BUSY SHALL be ignored (no state, counter or HI/LO change).
REQ-024 Undefined md_op with start SHALL be ignored.
REQ-025 stall_md = md_use_D & (busy | (start & md_op is mult/multu/div/divu)), combinational.
REQ-026 hi/lo SHALL change only per REQ-017/REQ-022; read values are registered outputs.

Reset
REQ-027 reset low SHALL immediately force state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, regardless of clock.
REQ-028 Reset mid-operation SHALL abandon the op; no HI/LO write after release.
REQ-029 First start honoured at first rising edge after reset deasserts.

Configuration
REQ-030 Macro MD_DIV_EN defined: div/divu per REQ-016..021.
REQ-031 MD_DIV_EN undefined: div/divu treated as undefined ops (REQ-024), no divider logic instantiated; stall_md excludes them.

Structure
REQ-032 Shared package SHALL hold md_op encodings, state encodings and default cycle constants.
REQ-033 Optional sub-module md_div_core (combinational signed/unsigned divider) under MD_DIV_EN; multiplier inline.

Verification
REQ-034 mult rs=0xFFFFFFFF rt=2 -> busy 5 cycles, hi=0xFFFFFFFF lo=0xFFFFFFFE, done once.
REQ-035 multu rs=0xFFFFFFFF rt=2 -> hi=0x00000001 lo=0xFFFFFFFE.
REQ-036 div rs=-7 rt=2 -> busy 10 cycles, lo=0xFFFFFFFD hi=0xFFFFFFFF; div by 0 -> hi/lo unchanged.
REQ-037 md_use_D=1 during busy -> stall_md=1 each busy cycle, 0 the cycle busy falls; start during busy ignored.
REQ-038 mtlo rs=0x12345678 -> lo=0x12345678 next cycle, busy 0, done 0.
REQ-039 reset pulsed at busy cycle 3 of mult -> busy 0, hi=lo=0 immediately, no done afterwards.
